sample_capture: RTL and testbench

Triggered acquisition front end that sits directly upstream of the sample memory read out by the UART sample reader. When armed, it watches the ADC stream for a level crossing on the selected slope. It then writes 2^ADDR_W decimated samples into the sample RAM starting at address 0. It pulses done, which drives the reader's activate input.

---
 rtl/sample_capture_pkg.sv | 15 +
 rtl/sample_capture_trigger_detect.sv | 49 ++++
 rtl/sample_capture.sv | 215 +++++++++++++++++++++
 tb/tb_sample_capture.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_capture_pkg.sv
// Shared types and constants for the triggered sample capture front end.
package sample_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRIME     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } capture_state_t;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/sample_capture_trigger_detect.sv
// Level-crossing detector: keeps the previous valid sample and flags a
// crossing of the latched level on the selected slope. Equality on both
// sides of the level never counts as a crossing.
module trigger_detect
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  output logic              hit
);

  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] prev_d;
  logic              rise_s;
  logic              fall_s;

  // Next previous-sample value: cleared while idle, refreshed on every valid sample.
  always_comb begin
    prev_d = prev_q;
    if (clear) begin
      prev_d = '0;
    end else if (sample_valid) begin
      prev_d = sample_data;
    end else begin
      prev_d = prev_q;
    end
  end

  // Previous-sample register.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_s = (prev_q < level) && (sample_data >= level);
  assign fall_s = (prev_q > level) && (sample_data <= level);
  assign hit    = sample_valid && ((slope == SLOPE_FALLING) ? fall_s : rise_s);

endmodule

// File: rtl/sample_capture.sv
// Triggered acquisition front end. After arm it primes on one sample, waits
// for a level crossing, then writes 2^ADDR_W decimated samples to the sample
// RAM from address 0 and pulses done.
// Optional forced trigger after AUTO_TRIG_CYCLES in WAIT_TRIG is enabled by
// defining SAMPLE_CAPTURE_AUTO_TRIG_EN.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int DATA_W           = 8,
  parameter int ADDR_W           = 8,
  parameter int DECIM_W          = 16,
  parameter int AUTO_TRIG_CYCLES = 5000000
) (
  input  logic               clk_50mhz,
  input  logic               reset,
  input  logic               arm,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic               trig_slope,
  input  logic [DECIM_W-1:0] decim,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  output logic               busy,
  output logic               triggered,
  output logic               done
);

  capture_state_t     state_q, state_d;
  logic [DATA_W-1:0]  level_q, level_d;
  logic               slope_q, slope_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               busy_q, busy_d;
  logic               triggered_q, triggered_d;
  logic               done_q, done_d;

  logic               hit_s;
  logic               det_valid_s;
  logic               det_clear_s;
  logic               trig_take_s;
  logic               dec_bypass_s;
  logic               dec_wrap_s;
  logic               last_wr_s;

  assign det_valid_s = adc_valid && ((state_q == ST_PRIME) || (state_q == ST_WAIT_TRIG));
  assign det_clear_s = (state_q == ST_IDLE);

  trigger_detect #(.DATA_W(DATA_W)) u_trigger_detect (
    .clk_50mhz    (clk_50mhz),
    .reset        (reset),
    .clear        (det_clear_s),
    .sample_valid (det_valid_s),
    .sample_data  (adc_data),
    .level        (level_q),
    .slope        (slope_q),
    .hit          (hit_s)
  );

`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
  localparam int AT_W = (AUTO_TRIG_CYCLES > 1) ? $clog2(AUTO_TRIG_CYCLES) : 1;
  logic [AT_W-1:0] at_cnt_q, at_cnt_d;
  logic            timeout_s;

  assign timeout_s = (at_cnt_q == AT_W'(AUTO_TRIG_CYCLES - 1));

  // Timeout counter: zero outside WAIT_TRIG, counts WAIT_TRIG cycles and holds at the limit.
  always_comb begin
    at_cnt_d = at_cnt_q;
    if (state_q != ST_WAIT_TRIG) begin
      at_cnt_d = '0;
    end else if (!timeout_s) begin
      at_cnt_d = at_cnt_q + AT_W'(1);
    end else begin
      at_cnt_d = at_cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      at_cnt_q <= '0;
    end else begin
      at_cnt_q <= at_cnt_d;
    end
  end

  assign trig_take_s = adc_valid && (hit_s || timeout_s);
`else
  assign trig_take_s = hit_s;
`endif

  // decim of 0 or 1 keeps every sample.
  assign dec_bypass_s = (decim <= DECIM_W'(1));
  assign dec_wrap_s   = dec_bypass_s ||
                        (({1'b0, dec_cnt_q} + (DECIM_W+1)'(1)) >= {1'b0, decim});
  // The final write is on the outputs this cycle; no further samples are taken.
  assign last_wr_s    = mem_we_q && (mem_addr_q == {ADDR_W{1'b1}});

  // FSM next state, decimation, addressing and registered output values.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    slope_d     = slope_q;
    wr_addr_d   = wr_addr_q;
    dec_cnt_d   = dec_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    triggered_d = triggered_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_addr_d = '0;
        wr_addr_d  = '0;
        dec_cnt_d  = '0;
        if (arm) begin
          level_d     = trig_level;
          slope_d     = trig_slope;
          triggered_d = 1'b0;
          state_d     = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (adc_valid) begin
          state_d = ST_WAIT_TRIG;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_WAIT_TRIG: begin
        if (trig_take_s) begin
          triggered_d = hit_s;
          state_d     = ST_CAPTURE;
          mem_we_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = adc_data;
          wr_addr_d   = ADDR_W'(1);
          dec_cnt_d   = dec_bypass_s ? '0 : DECIM_W'(1);
        end else begin
          state_d = ST_WAIT_TRIG;
        end
      end
      ST_CAPTURE: begin
        if (last_wr_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (adc_valid) begin
          dec_cnt_d = dec_wrap_s ? '0 : (dec_cnt_q + DECIM_W'(1));
          if (dec_cnt_q == '0) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr_q;
            mem_wdata_d = adc_data;
            wr_addr_d   = wr_addr_q + ADDR_W'(1);
          end else begin
            mem_we_d = 1'b0;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        mem_addr_d = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      slope_q     <= SLOPE_RISING;
      wr_addr_q   <= '0;
      dec_cnt_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      slope_q     <= slope_d;
      wr_addr_q   <= wr_addr_d;
      dec_cnt_q   <= dec_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: a trigger-detection vector table plus
// hand-written capture sequences (decimation, sparse valid, arm noise, abort).
module tb_sample_capture;
  import sample_capture_pkg::*;

  logic        clk_50mhz = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic [7:0]  trig_level = 8'h00;
  logic        trig_slope = 1'b0;
  logic [15:0] decim = 16'd1;
  logic [7:0]  adc_data = 8'h00;
  logic        adc_valid = 1'b0;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        triggered;
  logic        done;

  sample_capture #(
    .DATA_W(8), .ADDR_W(8), .DECIM_W(16), .AUTO_TRIG_CYCLES(100)
  ) dut (
    .clk_50mhz(clk_50mhz), .reset(reset), .arm(arm),
    .trig_level(trig_level), .trig_slope(trig_slope), .decim(decim),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .triggered(triggered), .done(done)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int tests = 0;
  int fails = 0;

  // Write monitor state (sampled 1 time unit after each rising edge).
  int         wcount = 0;
  int         done_cnt = 0;
  int         idx = 0;
  int         addr_err = 0;
  int         we_err = 0;
  int         done_err = 0;
  logic [7:0] cap [256];

  always @(posedge clk_50mhz) begin
    #1;
    if (reset) begin
      idx = 0;
    end else begin
      if (mem_we) begin
        if (32'(mem_addr) != idx) addr_err++;
        if (!busy) we_err++;
        cap[mem_addr] = mem_wdata;
        wcount++;
        idx++;
      end
      if (done) begin
        done_cnt++;
        if (!busy) done_err++;
        idx = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_50mhz);
    reset = 1'b1; arm = 1'b0; adc_valid = 1'b0;
    @(negedge clk_50mhz);
    @(negedge clk_50mhz);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    check("reset mem_wdata", 32'(mem_wdata), 32'h0);
    check("reset mem_we", 32'(mem_we), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset triggered", 32'(triggered), 32'h0);
    check("reset done", 32'(done), 32'h0);
    reset = 1'b0;
  endtask

  task automatic do_arm(input logic [7:0] lvl, input logic slp);
    @(negedge clk_50mhz);
    arm = 1'b1; trig_level = lvl; trig_slope = slp;
    @(negedge clk_50mhz);
    arm = 1'b0;
    check("arm busy", 32'(busy), 32'h1);
    check("arm clears triggered", 32'(triggered), 32'h0);
  endtask

  task automatic send_one(input logic [7:0] d);
    @(negedge clk_50mhz);
    adc_valid = 1'b1; adc_data = d;
    @(negedge clk_50mhz);
    adc_valid = 1'b0;
    @(negedge clk_50mhz);
  endtask

  // Ramp stream 0x00,0x01,... with 'gap' idle cycles between valid samples.
  // Stops on done (optionally arming in the done cycle) or after writing
  // address abort_at (then asserts reset for one edge).
  task automatic feed(input int gap, input int abort_at, input bit noise, input int budget);
    logic [7:0] v = 8'h00;
    int c = 0;
    int since = 0;
    bit finished = 1'b0;
    while (c < budget && !finished) begin
      @(negedge clk_50mhz);
      c++;
      if (abort_at >= 0 && mem_we && 32'(mem_addr) == abort_at) begin
        reset = 1'b1; adc_valid = 1'b0; arm = 1'b0;
        finished = 1'b1;
      end else if (done) begin
        arm = noise; adc_valid = 1'b0;
        finished = 1'b1;
      end else begin
        arm = noise && (c % 5 == 0);
        if (since == 0) begin
          adc_valid = 1'b1; adc_data = v; v = v + 8'h01;
        end else begin
          adc_valid = 1'b0;
        end
        since = (since == gap) ? 0 : since + 1;
      end
    end
    check("feed finished within budget", 32'(finished), 32'h1);
    @(negedge clk_50mhz);
    arm = 1'b0; adc_valid = 1'b0;
  endtask

  task automatic check_capture(input string name, input int step, input logic [7:0] last);
    int bad = 0;
    logic [7:0] e;
    for (int n = 0; n < 256; n++) begin
      e = 8'(32'h80 + step * n);
      if (cap[n] !== e) bad++;
    end
    check({name, " contents mismatches"}, 32'(bad), 32'h0);
    check({name, " addr0"}, 32'(cap[0]), 32'h80);
    check({name, " addr255"}, 32'(cap[255]), 32'(last));
  endtask

  // Full rising-0x80 ramp capture and its end-of-capture checks.
  task automatic full_capture(input string name, input logic [15:0] dm, input int step,
                              input logic [7:0] last, input int gap, input bit noise);
    int w0;
    int d0;
    decim = dm;
    w0 = wcount; d0 = done_cnt;
    do_arm(8'h80, SLOPE_RISING);
    feed(gap, -1, noise, 4000);
    repeat (3) @(negedge clk_50mhz);
    check({name, " write count"}, 32'(wcount - w0), 32'd256);
    check({name, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    check({name, " triggered"}, 32'(triggered), 32'h1);
    check({name, " busy after"}, 32'(busy), 32'h0);
    check({name, " mem_addr after"}, 32'(mem_addr), 32'h0);
    check_capture(name, step, last);
  endtask

  typedef struct {
    logic [7:0] level;
    logic       slope;
    logic [7:0] s0, s1, s2;
    int         exp_idx;
    logic [7:0] exp_data;
  } trig_vec_t;

  trig_vec_t tv [12];

  initial begin
    int w0;
    int d0;
    int first_idx;
    logic [7:0] sv [3];

    tv[0]  = '{8'h40, SLOPE_FALLING, 8'h50, 8'h40, 8'h40,  1, 8'h40};
    tv[1]  = '{8'h40, SLOPE_FALLING, 8'h40, 8'h40, 8'h40, -1, 8'h00};
    tv[2]  = '{8'h40, SLOPE_FALLING, 8'h41, 8'h3F, 8'h3F,  1, 8'h3F};
    tv[3]  = '{8'h40, SLOPE_FALLING, 8'h40, 8'h41, 8'h3F,  2, 8'h3F};
    tv[4]  = '{8'h80, SLOPE_RISING,  8'h7F, 8'h80, 8'h80,  1, 8'h80};
    tv[5]  = '{8'h80, SLOPE_RISING,  8'h80, 8'h80, 8'h81, -1, 8'h00};
    tv[6]  = '{8'h80, SLOPE_RISING,  8'h10, 8'h20, 8'hF0,  2, 8'hF0};
    tv[7]  = '{8'h80, SLOPE_RISING,  8'h80, 8'h80, 8'h80, -1, 8'h00};
    tv[8]  = '{8'h40, SLOPE_FALLING, 8'h00, 8'hFF, 8'h00,  2, 8'h00};
    tv[9]  = '{8'h80, SLOPE_RISING,  8'h90, 8'h10, 8'h90,  2, 8'h90};
    tv[10] = '{8'h80, SLOPE_FALLING, 8'h90, 8'h80, 8'h70,  1, 8'h80};
    tv[11] = '{8'h80, SLOPE_RISING,  8'h81, 8'h7F, 8'h7F, -1, 8'h00};

    decim = 16'd1;
    for (int i = 0; i < 12; i++) begin
      do_reset();
      do_arm(tv[i].level, tv[i].slope);
      w0 = wcount;
      first_idx = -1;
      sv[0] = tv[i].s0; sv[1] = tv[i].s1; sv[2] = tv[i].s2;
      for (int j = 0; j < 3; j++) begin
        send_one(sv[j]);
        if (first_idx < 0 && wcount > w0) first_idx = j;
      end
      check($sformatf("vec%0d trigger sample", i), 32'(first_idx), 32'(tv[i].exp_idx));
      check($sformatf("vec%0d triggered", i), 32'(triggered), 32'(tv[i].exp_idx >= 0));
      if (tv[i].exp_idx >= 0) begin
        check($sformatf("vec%0d first data", i), 32'(cap[0]), 32'(tv[i].exp_data));
      end else begin
        check($sformatf("vec%0d still waiting", i), 32'(busy), 32'h1);
      end
    end

    do_reset();
    full_capture("ramp decim1", 16'd1, 1, 8'h7F, 0, 1'b0);
    full_capture("ramp decim4", 16'd4, 4, 8'h7C, 0, 1'b0);
    full_capture("ramp decim0", 16'd0, 1, 8'h7F, 0, 1'b0);
    full_capture("sparse arm noise", 16'd1, 1, 8'h7F, 2, 1'b1);

    // Abort with reset right after the write to address 100.
    decim = 16'd1;
    w0 = wcount; d0 = done_cnt;
    do_arm(8'h80, SLOPE_RISING);
    feed(0, 100, 1'b0, 4000);
    check("abort mem_we", 32'(mem_we), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort done", 32'(done), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_50mhz);
      adc_valid = 1'b1; adc_data = 8'(k);
    end
    @(negedge clk_50mhz);
    adc_valid = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    check("abort write count", 32'(wcount - w0), 32'd101);
    check("abort no done", 32'(done_cnt - d0), 32'd0);
    full_capture("rearm after abort", 16'd1, 1, 8'h7F, 0, 1'b0);

`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
    begin
      int c = 0;
      int first_w = -1;
      int bad = 0;
      w0 = wcount; d0 = done_cnt;
      do_arm(8'h80, SLOPE_RISING);
      while (c < 3000 && done_cnt == d0) begin
        @(negedge clk_50mhz);
        adc_valid = 1'b1; adc_data = 8'h10;
        if (first_w < 0 && wcount > w0) first_w = c;
        c++;
      end
      adc_valid = 1'b0;
      repeat (3) @(negedge clk_50mhz);
      check("auto forced write count", 32'(wcount - w0), 32'd256);
      check("auto done pulses", 32'(done_cnt - d0), 32'd1);
      check("auto triggered", 32'(triggered), 32'h0);
      check("auto first write timing", 32'(first_w >= 100 && first_w <= 105), 32'h1);
      for (int n = 0; n < 256; n++) if (cap[n] !== 8'h10) bad++;
      check("auto contents mismatches", 32'(bad), 32'h0);
    end
`else
    w0 = wcount;
    do_arm(8'h80, SLOPE_RISING);
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk_50mhz);
      adc_valid = 1'b1; adc_data = 8'h10;
    end
    adc_valid = 1'b0;
    @(negedge clk_50mhz);
    check("no auto busy held", 32'(busy), 32'h1);
    check("no auto writes", 32'(wcount - w0), 32'd0);
    do_reset();
`endif

    check("address sequence errors", 32'(addr_err), 32'h0);
    check("mem_we while idle", 32'(we_err), 32'h0);
    check("done while idle", 32'(done_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
